// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;

    // True when the 8 data bits plus the parity bit hold an odd number of ones.
    function automatic logic ps2_odd_ones(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
// Module   : ps2_clk_filter
// Brief    : 2-FF synchronisers, PS2Clk glitch filter and falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic FPGAClk,
    input  logic rst,
    input  logic PS2Clk,
    input  logic datain,
    output logic fall,
    output logic toggle,
    output logic data_sync
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_level;
    logic [3:0] r_cnt;
    logic       r_fall;
    logic       r_toggle;
    logic       w_differ;
    logic       w_flip;

    assign w_differ = (r_clk_sync[1] != r_level);
    // The current sample is the FILTER_LEN-th consecutive one disagreeing.
    assign w_flip   = w_differ && (r_cnt == 4'(FILTER_LEN - 1));

    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_level    <= 1'b1;
            r_cnt      <= 4'd0;
            r_fall     <= 1'b0;
            r_toggle   <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2Clk};
            r_dat_sync <= {r_dat_sync[0], datain};
            r_fall     <= w_flip && r_level;
            r_toggle   <= w_flip;
            if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= 4'd0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign fall      = r_fall;
    assign toggle    = r_toggle;
    assign data_sync = r_dat_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 keyboard frame receiver with E0/F0 prefix stripping.
//            Define PS2_PARITY_CHECK_EN to enforce odd parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       FPGAClk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       datain,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       key_ext,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES);

    logic                w_fall;
    logic                w_toggle;
    logic                w_data;
    logic                w_timeout;
    logic                w_par_ok;

    ps2_state_t          r_state,   w_state_nxt;
    logic [7:0]          r_shift,   w_shift_nxt;
    logic [2:0]          r_bcnt,    w_bcnt_nxt;
    logic                r_brk,     w_brk_nxt;
    logic                r_ext,     w_ext_nxt;
    logic [7:0]          r_key,     w_key_nxt;
    logic                r_key_ext, w_key_ext_nxt;
    logic                r_kv,      w_kv_nxt;
    logic                r_ferr,    w_ferr_nxt;
    logic [c_tcnt_w-1:0] r_tcnt;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .FPGAClk   (FPGAClk),
        .rst       (rst),
        .PS2Clk    (PS2Clk),
        .datain    (datain),
        .fall      (w_fall),
        .toggle    (w_toggle),
        .data_sync (w_data)
    );

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;

    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_fall && !w_timeout && r_state == PARITY) begin
            r_par <= w_data;
        end
    end

    assign w_par_ok = ps2_odd_ones({r_shift, r_par});
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_timeout = (r_state != IDLE) && (r_tcnt == c_tcnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
        end else if (r_state == IDLE || w_toggle || w_timeout) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + c_tcnt_w'(1);
        end
    end

    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= 8'h00;
            r_bcnt    <= 3'd0;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_key     <= 8'h00;
            r_key_ext <= 1'b0;
            r_kv      <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_brk     <= w_brk_nxt;
            r_ext     <= w_ext_nxt;
            r_key     <= w_key_nxt;
            r_key_ext <= w_key_ext_nxt;
            r_kv      <= w_kv_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bcnt_nxt    = r_bcnt;
        w_brk_nxt     = r_brk;
        w_ext_nxt     = r_ext;
        w_key_nxt     = r_key;
        w_key_ext_nxt = r_key_ext;
        w_kv_nxt      = 1'b0;
        w_ferr_nxt    = 1'b0;

        // A timeout takes priority over any edge arriving in the same cycle.
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_ferr_nxt  = 1'b1;
            w_brk_nxt   = 1'b0;
            w_ext_nxt   = 1'b0;
        end else if (w_fall) begin
            case (r_state)
                IDLE: begin
                    if (!w_data) begin
                        w_state_nxt = DATA;
                        w_bcnt_nxt  = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {w_data, r_shift[7:1]};
                    if (r_bcnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end else begin
                        w_bcnt_nxt = r_bcnt + 3'd1;
                    end
                end
                PARITY: begin
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_data && w_par_ok) begin
                        if (r_shift == PS2_EXT) begin
                            w_ext_nxt = 1'b1;
                        end else if (r_shift == PS2_BREAK) begin
                            w_brk_nxt = 1'b1;
                        end else if (r_brk) begin
                            w_brk_nxt = 1'b0;
                            w_ext_nxt = 1'b0;
                        end else begin
                            w_key_nxt     = r_shift;
                            w_key_ext_nxt = r_ext;
                            w_kv_nxt      = 1'b1;
                            w_ext_nxt     = 1'b0;
                        end
                    end else begin
                        w_ferr_nxt = 1'b1;
                        w_brk_nxt  = 1'b0;
                        w_ext_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign key       = r_key;
    assign key_valid = r_kv;
    assign key_ext   = r_key_ext;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire
